// File: rtl/rx_cmd_ctrl_burst_if.sv
// Bus bundle between the RX deserialiser / RF / ALU side and the command controller.
interface rx_cmd_ctrl_burst_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int ALU_FUNC_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]     RX_P_DATA;
  logic                      RX_DATA_VLD;
  logic                      Rd_D_VLD;
  logic                      ALU_OUT_Valid;
  logic                      WrEn;
  logic                      RdEn;
  logic [ADDRESS_WIDTH-1:0]  Addr;
  logic [DATA_WIDTH-1:0]     Wr_D;
  logic                      Gate_EN;
  logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC;
  logic                      ALU_EN;
  logic                      BUSY;
  logic                      CMD_DONE;
  logic                      CMD_ERR;
  logic [1:0]                ERR_CODE;

  // Controller side: consumes bytes and handshakes, drives strobes and status.
  modport slave (
    input  RX_P_DATA, RX_DATA_VLD, Rd_D_VLD, ALU_OUT_Valid,
    output WrEn, RdEn, Addr, Wr_D, Gate_EN, ALU_FUNC, ALU_EN,
           BUSY, CMD_DONE, CMD_ERR, ERR_CODE
  );

  // Environment side: feeds bytes and handshakes, observes strobes and status.
  modport master (
    output RX_P_DATA, RX_DATA_VLD, Rd_D_VLD, ALU_OUT_Valid,
    input  WrEn, RdEn, Addr, Wr_D, Gate_EN, ALU_FUNC, ALU_EN,
           BUSY, CMD_DONE, CMD_ERR, ERR_CODE
  );
endinterface

// File: rtl/rx_cmd_ctrl_burst.sv
// RX command controller: decodes byte-framed commands into RF write/read
// strobes, burst writes and ALU requests, with per-command timeout and
// error reporting. All outputs are registered.
module rx_cmd_ctrl_burst #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] OP_WR      = DATA_WIDTH'(8'hAA),
  parameter logic [DATA_WIDTH-1:0] OP_RD      = DATA_WIDTH'(8'hBB),
  parameter logic [DATA_WIDTH-1:0] OP_ALU_OP  = DATA_WIDTH'(8'hCC),
  parameter logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD),
  parameter logic [DATA_WIDTH-1:0] OP_BURST   = DATA_WIDTH'(8'hEE)
) (
  input  logic                CLK,
  input  logic                RST,
  rx_cmd_ctrl_burst_if.slave  bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUNC     = 4'd7,
    ALU_WAIT = 4'd8,
    BW_ADDR  = 4'd9,
    BW_CNT   = 4'd10,
    BW_DATA  = 4'd11
  } state_t;

  state_t                    state_r, next_state_s;
  logic [ADDRESS_WIDTH-1:0]  addr_r, addr_s;     // latched / running write address
  logic [CW-1:0]             cnt_r, cnt_s;       // burst bytes still to write
  logic [TW-1:0]             tmo_r;
  logic                      progress_s, timeout_s, opcode_ok_s, bad_cnt_s;

  logic                      wr_en_r, wr_en_s;
  logic                      rd_en_r, rd_en_s;
  logic [ADDRESS_WIDTH-1:0]  addr_out_r, addr_out_s;
  logic [DATA_WIDTH-1:0]     wr_d_r, wr_d_s;
  logic                      gate_en_r, gate_en_s;
  logic [ALU_FUNC_WIDTH-1:0] alu_func_r, alu_func_s;
  logic                      alu_en_r, alu_en_s;
  logic                      busy_r, busy_s;
  logic                      done_r, done_s;
  logic                      err_r, err_s;
  logic [1:0]                err_code_r, err_code_s;

  // Any byte or handshake counts as progress; timeout fires on the last idle cycle.
  always_comb begin
    progress_s = bus.RX_DATA_VLD | bus.Rd_D_VLD | bus.ALU_OUT_Valid;
    timeout_s  = (TIMEOUT_CYCLES != 0) && (state_r != IDLE) && !progress_s &&
                 (tmo_r == TMO_LAST);
    bad_cnt_s  = (bus.RX_P_DATA == DATA_WIDTH'(0)) ||
                 (bus.RX_P_DATA > DATA_WIDTH'(MAX_BURST));
  end

  // Opcode recognition for the byte presented in IDLE.
  always_comb begin
    opcode_ok_s = 1'b0;
    case (bus.RX_P_DATA)
      OP_WR, OP_RD, OP_ALU_OP, OP_ALU_NOP, OP_BURST: opcode_ok_s = 1'b1;
      default:                                       opcode_ok_s = 1'b0;
    endcase
  end

  // State, latched address and burst count registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      addr_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state decode, including address latch and burst bookkeeping.
  always_comb begin
    next_state_s = state_r;
    addr_s       = addr_r;
    cnt_s        = cnt_r;
    if (timeout_s) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.RX_DATA_VLD) begin
            case (bus.RX_P_DATA)
              OP_WR:      next_state_s = WR_ADDR;
              OP_RD:      next_state_s = RD_ADDR;
              OP_ALU_OP:  next_state_s = OP_A;
              OP_ALU_NOP: next_state_s = FUNC;
              OP_BURST:   next_state_s = BW_ADDR;
              default:    next_state_s = IDLE;
            endcase
          end else next_state_s = IDLE;
        end
        WR_ADDR: begin
          if (bus.RX_DATA_VLD) begin
            addr_s       = bus.RX_P_DATA[ADDRESS_WIDTH-1:0];
            next_state_s = WR_DATA;
          end else next_state_s = WR_ADDR;
        end
        WR_DATA:  if (bus.RX_DATA_VLD) next_state_s = IDLE;     else next_state_s = WR_DATA;
        RD_ADDR:  if (bus.RX_DATA_VLD) next_state_s = RD_WAIT;  else next_state_s = RD_ADDR;
        RD_WAIT:  if (bus.Rd_D_VLD)    next_state_s = IDLE;     else next_state_s = RD_WAIT;
        OP_A:     if (bus.RX_DATA_VLD) next_state_s = OP_B;     else next_state_s = OP_A;
        OP_B:     if (bus.RX_DATA_VLD) next_state_s = FUNC;     else next_state_s = OP_B;
        FUNC:     if (bus.RX_DATA_VLD) next_state_s = ALU_WAIT; else next_state_s = FUNC;
        ALU_WAIT: if (bus.ALU_OUT_Valid) next_state_s = IDLE;   else next_state_s = ALU_WAIT;
        BW_ADDR: begin
          if (bus.RX_DATA_VLD) begin
            addr_s       = bus.RX_P_DATA[ADDRESS_WIDTH-1:0];
            next_state_s = BW_CNT;
          end else next_state_s = BW_ADDR;
        end
        BW_CNT: begin
          if (bus.RX_DATA_VLD) begin
            if (bad_cnt_s) begin
              next_state_s = IDLE;
            end else begin
              cnt_s        = bus.RX_P_DATA[CW-1:0];
              next_state_s = BW_DATA;
            end
          end else next_state_s = BW_CNT;
        end
        BW_DATA: begin
          if (bus.RX_DATA_VLD) begin
            // Address wraps naturally at 2**ADDRESS_WIDTH.
            addr_s = addr_r + ADDRESS_WIDTH'(1);
            cnt_s  = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) next_state_s = IDLE;
            else                 next_state_s = BW_DATA;
          end else next_state_s = BW_DATA;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Idle-cycle counter: cleared on progress or state change, counts otherwise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_r <= '0;
    end else if ((state_r == IDLE) || (next_state_s != state_r) || progress_s) begin
      tmo_r <= '0;
    end else begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    addr_out_s = addr_out_r;
    wr_d_s     = wr_d_r;
    alu_func_s = alu_func_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    err_code_s = err_code_r;
    if (timeout_s) begin
      err_s      = 1'b1;
      err_code_s = 2'b10;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.RX_DATA_VLD && !opcode_ok_s) begin
            err_s      = 1'b1;
            err_code_s = 2'b01;
          end else err_s = 1'b0;
        end
        WR_DATA: begin
          if (bus.RX_DATA_VLD) begin
            wr_en_s    = 1'b1;
            addr_out_s = addr_r;
            wr_d_s     = bus.RX_P_DATA;
            done_s     = 1'b1;
          end else done_s = 1'b0;
        end
        RD_ADDR: begin
          if (bus.RX_DATA_VLD) begin
            rd_en_s    = 1'b1;
            addr_out_s = bus.RX_P_DATA[ADDRESS_WIDTH-1:0];
          end else rd_en_s = 1'b0;
        end
        RD_WAIT:  if (bus.Rd_D_VLD)      done_s = 1'b1; else done_s = 1'b0;
        ALU_WAIT: if (bus.ALU_OUT_Valid) done_s = 1'b1; else done_s = 1'b0;
        OP_A, OP_B: begin
          if (bus.RX_DATA_VLD) begin
            wr_en_s    = 1'b1;
            addr_out_s = (state_r == OP_A) ? ADDRESS_WIDTH'(0) : ADDRESS_WIDTH'(1);
            wr_d_s     = bus.RX_P_DATA;
          end else wr_en_s = 1'b0;
        end
        FUNC: begin
          if (bus.RX_DATA_VLD) alu_func_s = bus.RX_P_DATA[ALU_FUNC_WIDTH-1:0];
          else                 alu_func_s = alu_func_r;
        end
        BW_CNT: begin
          if (bus.RX_DATA_VLD && bad_cnt_s) begin
            err_s      = 1'b1;
            err_code_s = 2'b11;
          end else err_s = 1'b0;
        end
        BW_DATA: begin
          if (bus.RX_DATA_VLD) begin
            wr_en_s    = 1'b1;
            addr_out_s = addr_r;
            wr_d_s     = bus.RX_P_DATA;
            done_s     = (cnt_r == CW'(1));
          end else wr_en_s = 1'b0;
        end
        default: done_s = 1'b0;
      endcase
    end
    // Level outputs follow the state being entered so they line up with it.
    gate_en_s = (next_state_s == FUNC) || (next_state_s == ALU_WAIT);
    alu_en_s  = (next_state_s == ALU_WAIT);
    busy_s    = (next_state_s != IDLE);
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
      addr_out_r <= '0;
      wr_d_r     <= '0;
      gate_en_r  <= 1'b0;
      alu_func_r <= '0;
      alu_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
    end else begin
      wr_en_r    <= wr_en_s;
      rd_en_r    <= rd_en_s;
      addr_out_r <= addr_out_s;
      wr_d_r     <= wr_d_s;
      gate_en_r  <= gate_en_s;
      alu_func_r <= alu_func_s;
      alu_en_r   <= alu_en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      err_code_r <= err_code_s;
    end
  end

  assign bus.WrEn     = wr_en_r;
  assign bus.RdEn     = rd_en_r;
  assign bus.Addr     = addr_out_r;
  assign bus.Wr_D     = wr_d_r;
  assign bus.Gate_EN  = gate_en_r;
  assign bus.ALU_FUNC = alu_func_r;
  assign bus.ALU_EN   = alu_en_r;
  assign bus.BUSY     = busy_r;
  assign bus.CMD_DONE = done_r;
  assign bus.CMD_ERR  = err_r;
  assign bus.ERR_CODE = err_code_r;

endmodule

// File: tb/tb_rx_cmd_ctrl_burst.sv
// Directed bench for rx_cmd_ctrl_burst (timeout shortened to 16 cycles).
module tb_rx_cmd_ctrl_burst;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  rx_cmd_ctrl_burst_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUNC_WIDTH(4)) bus_if ();

  rx_cmd_ctrl_burst #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUNC_WIDTH(4),
    .MAX_BURST(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.RX_P_DATA   = b;
    bus_if.RX_DATA_VLD = 1'b1;
    tick();
    bus_if.RX_DATA_VLD = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_if.RX_P_DATA     = 8'h00;
    bus_if.RX_DATA_VLD   = 1'b0;
    bus_if.Rd_D_VLD      = 1'b0;
    bus_if.ALU_OUT_Valid = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_wren",  32'(bus_if.WrEn),     32'h0);
    chk("rst_busy",  32'(bus_if.BUSY),     32'h0);
    chk("rst_addr",  32'(bus_if.Addr),     32'h0);
    chk("rst_ecode", 32'(bus_if.ERR_CODE), 32'h0);
    chk("rst_gate",  32'(bus_if.Gate_EN),  32'h0);
    RST = 1'b0;
    tick();

    // Single write AA,05,3C
    send(8'hAA);
    chk("wr_busy_on", 32'(bus_if.BUSY), 32'h1);
    send(8'h05);
    chk("wr_no_early", 32'(bus_if.WrEn), 32'h0);
    send(8'h3C);
    chk("wr_wren", 32'(bus_if.WrEn),     32'h1);
    chk("wr_addr", 32'(bus_if.Addr),     32'h5);
    chk("wr_data", 32'(bus_if.Wr_D),     32'h3C);
    chk("wr_done", 32'(bus_if.CMD_DONE), 32'h1);
    chk("wr_busy", 32'(bus_if.BUSY),     32'h0);
    tick();
    chk("wr_pulse", 32'(bus_if.WrEn),     32'h0);
    chk("wr_done1", 32'(bus_if.CMD_DONE), 32'h0);

    // Read BB,07 with a dropped byte in RD_WAIT, Rd_D_VLD 3 cycles later
    send(8'hBB);
    send(8'h07);
    chk("rd_rden", 32'(bus_if.RdEn),     32'h1);
    chk("rd_addr", 32'(bus_if.Addr),     32'h7);
    chk("rd_nodn", 32'(bus_if.CMD_DONE), 32'h0);
    tick();
    chk("rd_pulse", 32'(bus_if.RdEn), 32'h0);
    send(8'h99);
    chk("rd_drop_err",  32'(bus_if.CMD_ERR), 32'h0);
    chk("rd_drop_busy", 32'(bus_if.BUSY),    32'h1);
    bus_if.Rd_D_VLD = 1'b1;
    tick();
    bus_if.Rd_D_VLD = 1'b0;
    chk("rd_done", 32'(bus_if.CMD_DONE), 32'h1);
    chk("rd_busy", 32'(bus_if.BUSY),     32'h0);

    // ALU CC,12,34,02; valid 4 cycles later together with a stray byte
    send(8'hCC);
    send(8'h12);
    chk("alu_wa_en",   32'(bus_if.WrEn), 32'h1);
    chk("alu_wa_addr", 32'(bus_if.Addr), 32'h0);
    chk("alu_wa_data", 32'(bus_if.Wr_D), 32'h12);
    chk("alu_gate_pre", 32'(bus_if.Gate_EN), 32'h0);
    send(8'h34);
    chk("alu_wb_addr", 32'(bus_if.Addr),    32'h1);
    chk("alu_wb_data", 32'(bus_if.Wr_D),    32'h34);
    chk("alu_gate_fn", 32'(bus_if.Gate_EN), 32'h1);
    chk("alu_en_fn",   32'(bus_if.ALU_EN),  32'h0);
    send(8'h02);
    chk("alu_func", 32'(bus_if.ALU_FUNC), 32'h2);
    chk("alu_en_c1", 32'(bus_if.ALU_EN), 32'h1);
    tick();
    chk("alu_en_c2", 32'(bus_if.ALU_EN), 32'h1);
    tick();
    chk("alu_en_c3", 32'(bus_if.ALU_EN), 32'h1);
    tick();
    chk("alu_en_c4", 32'(bus_if.ALU_EN),  32'h1);
    chk("alu_gate4", 32'(bus_if.Gate_EN), 32'h1);
    bus_if.ALU_OUT_Valid = 1'b1;
    bus_if.RX_P_DATA     = 8'h77;
    bus_if.RX_DATA_VLD   = 1'b1;
    tick();
    bus_if.ALU_OUT_Valid = 1'b0;
    bus_if.RX_DATA_VLD   = 1'b0;
    chk("alu_en_off", 32'(bus_if.ALU_EN),   32'h0);
    chk("alu_gate_off", 32'(bus_if.Gate_EN), 32'h0);
    chk("alu_done",   32'(bus_if.CMD_DONE), 32'h1);
    chk("alu_noerr",  32'(bus_if.CMD_ERR),  32'h0);
    chk("alu_func_hold", 32'(bus_if.ALU_FUNC), 32'h2);

    // Burst EE,0E,03,11,22,33 with address wrap
    send(8'hEE);
    send(8'h0E);
    send(8'h03);
    send(8'h11);
    chk("bw0_addr", 32'(bus_if.Addr),     32'hE);
    chk("bw0_data", 32'(bus_if.Wr_D),     32'h11);
    chk("bw0_nodn", 32'(bus_if.CMD_DONE), 32'h0);
    send(8'h22);
    chk("bw1_addr", 32'(bus_if.Addr), 32'hF);
    chk("bw1_wren", 32'(bus_if.WrEn), 32'h1);
    send(8'h33);
    chk("bw2_addr", 32'(bus_if.Addr),     32'h0);
    chk("bw2_data", 32'(bus_if.Wr_D),     32'h33);
    chk("bw2_done", 32'(bus_if.CMD_DONE), 32'h1);
    chk("bw2_busy", 32'(bus_if.BUSY),     32'h0);

    // Error paths: count 0, bad opcode, count above MAX_BURST
    send(8'hEE);
    send(8'h00);
    send(8'h00);
    chk("bc0_err",   32'(bus_if.CMD_ERR),  32'h1);
    chk("bc0_code",  32'(bus_if.ERR_CODE), 32'h3);
    chk("bc0_nodn",  32'(bus_if.CMD_DONE), 32'h0);
    chk("bc0_busy",  32'(bus_if.BUSY),     32'h0);
    send(8'h5A);
    chk("op_err",  32'(bus_if.CMD_ERR),  32'h1);
    chk("op_code", 32'(bus_if.ERR_CODE), 32'h1);
    chk("op_busy", 32'(bus_if.BUSY),     32'h0);
    send(8'hEE);
    send(8'h00);
    send(8'h05);
    chk("bc5_err",  32'(bus_if.CMD_ERR),  32'h1);
    chk("bc5_code", 32'(bus_if.ERR_CODE), 32'h3);
    tick();
    chk("err_pulse", 32'(bus_if.CMD_ERR),  32'h0);
    chk("code_hold", 32'(bus_if.ERR_CODE), 32'h3);

    // Timeout in ALU_WAIT drops ALU_EN/Gate_EN after 16 idle cycles
    send(8'hDD);
    chk("nop_gate", 32'(bus_if.Gate_EN), 32'h1);
    send(8'h05);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_alu_pre", 32'(bus_if.ALU_EN),  32'h1);
    chk("tmo_alu_pre_err", 32'(bus_if.CMD_ERR), 32'h0);
    tick();
    chk("tmo_alu_en",   32'(bus_if.ALU_EN),   32'h0);
    chk("tmo_alu_gate", 32'(bus_if.Gate_EN),  32'h0);
    chk("tmo_alu_err",  32'(bus_if.CMD_ERR),  32'h1);
    chk("tmo_alu_code", 32'(bus_if.ERR_CODE), 32'h2);

    // Timeout after AA then silence
    send(8'h5A);
    chk("op2_code", 32'(bus_if.ERR_CODE), 32'h1);
    send(8'hAA);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_wr_pre",  32'(bus_if.CMD_ERR), 32'h0);
    chk("tmo_wr_busy", 32'(bus_if.BUSY),    32'h1);
    tick();
    chk("tmo_wr_err",  32'(bus_if.CMD_ERR),  32'h1);
    chk("tmo_wr_code", 32'(bus_if.ERR_CODE), 32'h2);
    chk("tmo_wr_idle", 32'(bus_if.BUSY),     32'h0);

    // Reset mid-burst
    send(8'hEE);
    send(8'h02);
    send(8'h02);
    send(8'h44);
    chk("mb_wren", 32'(bus_if.WrEn), 32'h1);
    chk("mb_addr", 32'(bus_if.Addr), 32'h2);
    RST = 1'b1;
    bus_if.RX_P_DATA   = 8'h55;
    bus_if.RX_DATA_VLD = 1'b1;
    tick();
    bus_if.RX_DATA_VLD = 1'b0;
    chk("mr_wren",  32'(bus_if.WrEn),     32'h0);
    chk("mr_busy",  32'(bus_if.BUSY),     32'h0);
    chk("mr_err",   32'(bus_if.CMD_ERR),  32'h0);
    chk("mr_done",  32'(bus_if.CMD_DONE), 32'h0);
    chk("mr_code",  32'(bus_if.ERR_CODE), 32'h0);
    chk("mr_addr",  32'(bus_if.Addr),     32'h0);
    RST = 1'b0;
    tick();
    chk("mr_quiet", 32'(bus_if.WrEn), 32'h0);
    send(8'h66);
    chk("mr_idle_err",  32'(bus_if.CMD_ERR),  32'h1);
    chk("mr_idle_code", 32'(bus_if.ERR_CODE), 32'h1);
    send(8'hAA);
    send(8'h01);
    send(8'h77);
    chk("post_wren", 32'(bus_if.WrEn), 32'h1);
    chk("post_addr", 32'(bus_if.Addr), 32'h1);
    chk("post_data", 32'(bus_if.Wr_D), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
